iact_spad_window: RTL and testbench

Per-PE input-activation scratchpad with sliding-window readout. It sits directly downstream of the iact GLB router and captures one act_size×act_size activation plane from the `w_data_spad`/`load_en_spad` stream. On request it replays the plane to the MAC as a sequence of kernel_size×kernel_size windows over valid-convolution positions, using a valid/ready handshake. Completion is reported so control can trigger the next GLB load.

---
 rtl/iact_spad_window_pkg.sv | 35 +++
 rtl/iact_spad_window_if.sv | 44 ++++
 rtl/iact_spad_window_addr_gen.sv | 82 ++++++++
 rtl/iact_spad_window.sv | 151 +++++++++++++++
 tb/tb_iact_spad_window.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/iact_spad_window_pkg.sv
// -----------------------------------------------------------------------------
// iact_pkg
// Shared constants for the per-PE input-activation scratchpad.
//   - plane geometry (act_size, kernel_size) and word/address widths
//   - derived sizes: NUM_WORDS, OUT_DIM, WIN_WORDS, STREAM_WORDS
//   - FSM state encoding (EMPTY, FULL, STREAM)
//   - win_addr(): flat plane address of one window tap
// No ports.
// -----------------------------------------------------------------------------
package iact_pkg;

    localparam int DATA_BITWIDTH      = 16;
    localparam int ADDR_BITWIDTH_SPAD = 9;
    localparam int act_size           = 5;
    localparam int kernel_size        = 3;

    localparam int NUM_WORDS    = act_size * act_size;
    localparam int OUT_DIM      = act_size - kernel_size + 1;
    localparam int WIN_WORDS    = kernel_size * kernel_size;
    localparam int STREAM_WORDS = OUT_DIM * OUT_DIM * WIN_WORDS;

    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] FULL   = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    typedef logic [DATA_BITWIDTH-1:0]      data_t;
    typedef logic [ADDR_BITWIDTH_SPAD-1:0] addr_t;

    // Row-major address of tap (ky,kx) of the window anchored at (oy,ox).
    function automatic addr_t win_addr(input addr_t oy, input addr_t ox,
                                       input addr_t ky, input addr_t kx);
        return (oy + ky) * addr_t'(act_size) + (ox + kx);
    endfunction

endpackage

// File: rtl/iact_spad_window_if.sv
// -----------------------------------------------------------------------------
// iact_spad_window_if
// Bundles the router-side load stream and the MAC-side window stream.
//   w_data_spad / load_en_spad : activation words from the GLB router
//   spad_full                  : plane loaded and not yet consumed
//   start_win                  : request to stream windows
//   iact_data/valid/ready/last : window word handshake to the MAC
//   iact_done                  : pulse after the final word is accepted
//   ovf_err                    : sticky misuse flag (IACT_SPAD_OVF_CHECK_EN only)
// Modports: slave = scratchpad, master = router/MAC side.
// -----------------------------------------------------------------------------
interface iact_spad_window_if;
    import iact_pkg::*;

    data_t w_data_spad;
    logic  load_en_spad;
    logic  spad_full;
    logic  start_win;
    data_t iact_data;
    logic  iact_valid;
    logic  iact_ready;
    logic  iact_last;
    logic  iact_done;
`ifdef IACT_SPAD_OVF_CHECK_EN
    logic  ovf_err;
`endif

    modport slave (
        input  w_data_spad, load_en_spad, start_win, iact_ready,
        output spad_full, iact_data, iact_valid, iact_last, iact_done
`ifdef IACT_SPAD_OVF_CHECK_EN
        , output ovf_err
`endif
    );

    modport master (
        output w_data_spad, load_en_spad, start_win, iact_ready,
        input  spad_full, iact_data, iact_valid, iact_last, iact_done
`ifdef IACT_SPAD_OVF_CHECK_EN
        , input ovf_err
`endif
    );

endinterface

// File: rtl/iact_spad_window_addr_gen.sv
// -----------------------------------------------------------------------------
// iact_win_addr_gen
// Sliding-window counters (oy outer, ox, ky, kx innermost).
//   clk, reset       : clock, async active-low reset
//   step             : advance to the next window tap
//   clear            : return all counters to zero
//   cur_addr         : address of the tap the counters point at
//   next_addr        : address of the tap after that (wraps to 0 at the end)
//   cur_win_last     : current tap closes a window
//   next_win_last    : following tap closes a window
//   cur_stream_last  : current tap is the final tap of the whole stream
// -----------------------------------------------------------------------------
module iact_win_addr_gen
    import iact_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  step,
    input  logic  clear,
    output addr_t cur_addr,
    output addr_t next_addr,
    output logic  cur_win_last,
    output logic  next_win_last,
    output logic  cur_stream_last
);

    localparam addr_t K_MAX = addr_t'(kernel_size - 1);
    localparam addr_t O_MAX = addr_t'(OUT_DIM - 1);

    addr_t kx, ky, ox, oy;
    addr_t nkx, nky, nox, noy;

    // Odometer increment: kx carries into ky, ky into ox, ox into oy.
    always_comb begin
        nkx = kx;
        nky = ky;
        nox = ox;
        noy = oy;
        if (kx == K_MAX) begin
            nkx = '0;
            if (ky == K_MAX) begin
                nky = '0;
                if (ox == O_MAX) begin
                    nox = '0;
                    noy = (oy == O_MAX) ? '0 : oy + addr_t'(1);
                end else begin
                    nox = ox + addr_t'(1);
                end
            end else begin
                nky = ky + addr_t'(1);
            end
        end else begin
            nkx = kx + addr_t'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kx <= '0;
            ky <= '0;
            ox <= '0;
            oy <= '0;
        end else if (clear) begin
            kx <= '0;
            ky <= '0;
            ox <= '0;
            oy <= '0;
        end else if (step) begin
            kx <= nkx;
            ky <= nky;
            ox <= nox;
            oy <= noy;
        end
    end

    assign cur_addr        = win_addr(oy, ox, ky, kx);
    assign next_addr       = win_addr(noy, nox, nky, nkx);
    assign cur_win_last    = (ky == K_MAX) && (kx == K_MAX);
    assign next_win_last   = (nky == K_MAX) && (nkx == K_MAX);
    assign cur_stream_last = cur_win_last && (ox == O_MAX) && (oy == O_MAX);

endmodule

// File: rtl/iact_spad_window.sv
// -----------------------------------------------------------------------------
// iact_spad_window
// Per-PE activation scratchpad: captures one act_size x act_size plane from
// the router, then replays it as kernel_size x kernel_size windows over all
// valid-convolution positions.
//   clk   : clock
//   reset : async active-low reset
//   bus   : iact_spad_window_if.slave (load stream, window stream, status)
// Optional feature: define IACT_SPAD_OVF_CHECK_EN to add the sticky ovf_err
// output flagging dropped writes and starts issued while the plane is empty.
// -----------------------------------------------------------------------------
module iact_spad_window
    import iact_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    iact_spad_window_if.slave  bus
);

    localparam addr_t LAST_WPTR = addr_t'(NUM_WORDS - 1);

    data_t      mem [NUM_WORDS];
    addr_t      wptr;
    logic [1:0] state;

    data_t out_data;
    logic  out_valid;
    logic  out_last;
    logic  out_done;
    logic  out_full;

    addr_t cur_addr, next_addr, rd_addr;
    logic  cur_win_last, next_win_last, cur_stream_last;
    data_t rd_data;
    logic  wr_en, handshake, step, clear;

    assign wr_en     = (state == EMPTY) && bus.load_en_spad;
    assign handshake = (state == STREAM) && out_valid && bus.iact_ready;
    assign step      = handshake && !cur_stream_last;
    assign clear     = handshake && cur_stream_last;

    // The counters always point at the word on iact_data, so the start of a
    // stream reads the current tap while each handshake reads the following one.
    assign rd_addr = (state == STREAM) ? next_addr : cur_addr;

    iact_win_addr_gen u_addr_gen (
        .clk             (clk),
        .reset           (reset),
        .step            (step),
        .clear           (clear),
        .cur_addr        (cur_addr),
        .next_addr       (next_addr),
        .cur_win_last    (cur_win_last),
        .next_win_last   (next_win_last),
        .cur_stream_last (cur_stream_last)
    );

    // Plane storage; contents survive reset and are simply overwritten by the
    // next load.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (wr_en && (wptr == addr_t'(i))) begin
                mem[i] <= bus.w_data_spad;
            end
        end
    end

    // Full-width compare keeps out-of-range addresses reading zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (rd_addr == addr_t'(i)) begin
                rd_data = mem[i];
            end
        end
    end

    // Load / stream FSM and the output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            wptr      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_done  <= 1'b0;
            out_full  <= 1'b0;
        end else begin
            out_done <= 1'b0;
            case (state)
                EMPTY: begin
                    if (bus.load_en_spad) begin
                        if (wptr == LAST_WPTR) begin
                            wptr     <= '0;
                            state    <= FULL;
                            out_full <= 1'b1;
                        end else begin
                            wptr <= wptr + addr_t'(1);
                        end
                    end
                end
                FULL: begin
                    if (bus.start_win) begin
                        state     <= STREAM;
                        out_valid <= 1'b1;
                        out_data  <= rd_data;
                        out_last  <= cur_win_last;
                    end
                end
                STREAM: begin
                    if (!out_valid || bus.iact_ready) begin
                        if (cur_stream_last) begin
                            state     <= EMPTY;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_done  <= 1'b1;
                            out_full  <= 1'b0;
                        end else begin
                            out_data <= rd_data;
                            out_last <= next_win_last;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.iact_data  = out_data;
    assign bus.iact_valid = out_valid;
    assign bus.iact_last  = out_last;
    assign bus.iact_done  = out_done;
    assign bus.spad_full  = out_full;

`ifdef IACT_SPAD_OVF_CHECK_EN
    logic ovf_q;

    // Sticky until reset: any write outside EMPTY or start inside EMPTY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if ((bus.load_en_spad && (state != EMPTY)) ||
                     (bus.start_win && (state == EMPTY))) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf_err = ovf_q;
`endif

endmodule

// File: tb/tb_iact_spad_window.sv
// -----------------------------------------------------------------------------
// tb_iact_spad_window
// Self-checking bench for iact_spad_window. The reference model holds the
// plane in an array and builds the expected window stream with nested loops.
// -----------------------------------------------------------------------------
module tb_iact_spad_window;
    import iact_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    iact_spad_window_if bus();

    iact_spad_window dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    data_t plane [NUM_WORDS];
    data_t expData [$];
    logic  expLast [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Expected stream straight from the window definition.
    task automatic buildExpected();
        expData.delete();
        expLast.delete();
        for (int oy = 0; oy < OUT_DIM; oy++)
            for (int ox = 0; ox < OUT_DIM; ox++)
                for (int ky = 0; ky < kernel_size; ky++)
                    for (int kx = 0; kx < kernel_size; kx++) begin
                        expData.push_back(plane[(oy + ky) * act_size + ox + kx]);
                        expLast.push_back((ky == kernel_size - 1) && (kx == kernel_size - 1));
                    end
    endtask

    task automatic fillRamp(input int base);
        for (int i = 0; i < NUM_WORDS; i++) plane[i] = data_t'(base + i);
    endtask

    task automatic fillRandom();
        for (int i = 0; i < NUM_WORDS; i++) plane[i] = data_t'($urandom);
    endtask

    // One load cycle; called and returns at a falling edge.
    task automatic applyStimulus(input data_t word);
        bus.w_data_spad  = word;
        bus.load_en_spad = 1'b1;
        @(negedge clk);
        bus.load_en_spad = 1'b0;
    endtask

    task automatic loadPlane(input int first);
        for (int i = first; i < NUM_WORDS; i++) begin
            applyStimulus(plane[i]);
            if (i == NUM_WORDS - 2) checkOutput("full_early", bus.spad_full, 1'b0);
        end
        checkOutput("full_set", bus.spad_full, 1'b1);
    endtask

    // mode 0: ready always high, 1: 3-cycle stall on word 4, 2: random ready.
    // Returns at the falling edge where iact_done is expected high, or early
    // at word abortAt (abortAt < 0 disables that).
    task automatic streamPlane(input int mode, input int abortAt);
        int idx    = 0;
        int stalls = 0;
        int cyc    = 0;
        buildExpected();
        bus.start_win = 1'b1;
        @(negedge clk);
        bus.start_win = 1'b0;
        checkOutput("full_in_stream", bus.spad_full, 1'b1);
        while (idx < STREAM_WORDS && cyc < 4 * STREAM_WORDS + 50) begin
            if (idx == abortAt) begin
                bus.iact_ready = 1'b0;
                return;
            end
            checkOutput($sformatf("valid[%0d]", idx), bus.iact_valid, 1'b1);
            checkOutput($sformatf("data[%0d]", idx), bus.iact_data, expData[idx]);
            checkOutput($sformatf("last[%0d]", idx), bus.iact_last, expLast[idx]);
            checkOutput($sformatf("done_low[%0d]", idx), bus.iact_done, 1'b0);
            case (mode)
                0: bus.iact_ready = 1'b1;
                1: begin
                    if (idx == 4 && stalls < 3) begin
                        bus.iact_ready = 1'b0;
                        stalls++;
                    end else begin
                        bus.iact_ready = 1'b1;
                    end
                end
                default: bus.iact_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (bus.iact_valid && bus.iact_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        bus.iact_ready = 1'b0;
        if (idx < STREAM_WORDS) begin
            checkOutput("stream_timeout", idx, STREAM_WORDS);
            return;
        end
        checkOutput("end_valid", bus.iact_valid, 1'b0);
        checkOutput("end_done", bus.iact_done, 1'b1);
        checkOutput("end_full", bus.spad_full, 1'b0);
    endtask

    task automatic checkDoneDrop();
        @(negedge clk);
        checkOutput("done_drop", bus.iact_done, 1'b0);
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.w_data_spad  = '0;
        bus.load_en_spad = 1'b0;
        bus.start_win    = 1'b0;
        bus.iact_ready   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", bus.iact_valid, 1'b0);
        checkOutput("rst_last", bus.iact_last, 1'b0);
        checkOutput("rst_done", bus.iact_done, 1'b0);
        checkOutput("rst_full", bus.spad_full, 1'b0);
        checkOutput("rst_data", bus.iact_data, '0);
`ifdef IACT_SPAD_OVF_CHECK_EN
        checkOutput("rst_ovf", bus.ovf_err, 1'b0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Ramp plane, full-rate stream
        fillRamp(100);
        loadPlane(0);
        streamPlane(0, -1);
        checkDoneDrop();
`ifdef IACT_SPAD_OVF_CHECK_EN
        checkOutput("ovf_clean", bus.ovf_err, 1'b0);
`endif

        // Backpressure on word 4
        loadPlane(0);
        streamPlane(1, -1);
        checkDoneDrop();

        // 26th write is dropped
        loadPlane(0);
        applyStimulus(data_t'(16'hBEEF));
        checkOutput("full_after_extra", bus.spad_full, 1'b1);
`ifdef IACT_SPAD_OVF_CHECK_EN
        checkOutput("ovf_extra_write", bus.ovf_err, 1'b1);
`endif
        streamPlane(2, -1);
        checkDoneDrop();

        // Early start after 10 writes is ignored
        pulseReset();
        fillRandom();
        for (int i = 0; i < 10; i++) applyStimulus(plane[i]);
        bus.start_win = 1'b1;
        @(negedge clk);
        bus.start_win = 1'b0;
        checkOutput("early_start_valid", bus.iact_valid, 1'b0);
        checkOutput("early_start_full", bus.spad_full, 1'b0);
`ifdef IACT_SPAD_OVF_CHECK_EN
        checkOutput("ovf_early_start", bus.ovf_err, 1'b1);
`endif
        @(negedge clk);
        checkOutput("early_start_valid2", bus.iact_valid, 1'b0);
        loadPlane(10);
        streamPlane(2, -1);
        checkDoneDrop();

        // Reset in the middle of a stream
        fillRandom();
        loadPlane(0);
        streamPlane(0, 40);
        reset = 1'b0;
        #1;
        checkOutput("midrst_valid", bus.iact_valid, 1'b0);
        checkOutput("midrst_last", bus.iact_last, 1'b0);
        checkOutput("midrst_done", bus.iact_done, 1'b0);
        checkOutput("midrst_full", bus.spad_full, 1'b0);
        checkOutput("midrst_data", bus.iact_data, '0);
`ifdef IACT_SPAD_OVF_CHECK_EN
        checkOutput("midrst_ovf", bus.ovf_err, 1'b0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        fillRandom();
        loadPlane(0);
        streamPlane(2, -1);
        checkDoneDrop();

        // Back-to-back planes: next load starts in the iact_done cycle
        fillRandom();
        loadPlane(0);
        streamPlane(2, -1);
        fillRandom();
        applyStimulus(plane[0]);
        checkOutput("b2b_done_drop", bus.iact_done, 1'b0);
        loadPlane(1);
        streamPlane(2, -1);
        checkDoneDrop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
